// File: rtl/reg_status_table.sv
// Register status table (RST) for the out-of-order core.
// Tracks, per architectural register, whether a result is still outstanding
// and which tag will produce it. Dispatch binds a tag to rd, CDB broadcasts
// release the matching entry, flush clears everything.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   flush               clear all bindings (mispredict)
//   disp_wr_en/rd/tag   bind disp_tag to disp_rd_addr (x0 dropped)
//   rs1_*/rs2_*         combinational source lookups with CDB bypass
//   cdb_tag_valid/tag   result broadcast, clears the owning entry
//   pending_cnt         registered number of valid entries
//   rst_empty           pending_cnt == 0
module reg_status_table #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 6,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int CNT_W    = $clog2(NUM_REGS) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              flush,
  input  logic              disp_wr_en,
  input  logic [ADDR_W-1:0] disp_rd_addr,
  input  logic [TAG_W-1:0]  disp_tag,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_pending,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic              rs2_pending,
  output logic [TAG_W-1:0]  rs2_tag,
  input  logic              cdb_tag_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              rst_empty
);

  logic [NUM_REGS-1:0]            valid_q, valid_d;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_q,   tag_d;
  logic [CNT_W-1:0]               cnt_q,   cnt_d;

  // Per-entry next state. Dispatch wins over a CDB clear of the same entry,
  // so a reused tag re-bound in the CDB cycle stays live.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
    logic disp_hit, cdb_hit;
    if (i == 0) begin : g_x0
      assign disp_hit   = 1'b0;
      assign cdb_hit    = 1'b0;
      assign valid_d[i] = 1'b0;
      assign tag_d[i]   = '0;
    end else begin : g_xn
      assign disp_hit   = disp_wr_en && (disp_rd_addr == ADDR_W'(i));
      assign cdb_hit    = cdb_tag_valid && valid_q[i] && (tag_q[i] == cdb_tag);
      assign valid_d[i] = !flush && (disp_hit || (valid_q[i] && !cdb_hit));
      assign tag_d[i]   = (!flush && disp_hit) ? disp_tag : tag_q[i];
    end
  end

  // Count is a straight popcount of the next-state vector, which keeps it
  // exact across WAW overwrites and dispatch/CDB collisions.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d = cnt_d + CNT_W'(valid_d[i]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lookups read current state only (no same-cycle dispatch forwarding) but
  // bypass a same-cycle CDB completion.
  function automatic logic lk_pend(input logic [ADDR_W-1:0] a);
    lk_pend = (a != '0) && valid_q[a] && !(cdb_tag_valid && (cdb_tag == tag_q[a]));
  endfunction

  assign rs1_pending = lk_pend(rs1_addr);
  assign rs2_pending = lk_pend(rs2_addr);
  assign rs1_tag     = rs1_pending ? tag_q[rs1_addr] : '0;
  assign rs2_tag     = rs2_pending ? tag_q[rs2_addr] : '0;

  assign pending_cnt = cnt_q;
  assign rst_empty   = (cnt_q == '0);

endmodule

// File: tb/tb_reg_status_table.sv
module tb_reg_status_table;
  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 6;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 6;

  logic              i_clk = 1'b0;
  logic              i_rst, flush, disp_wr_en, cdb_tag_valid;
  logic [ADDR_W-1:0] disp_rd_addr, rs1_addr, rs2_addr;
  logic [TAG_W-1:0]  disp_tag, cdb_tag, rs1_tag, rs2_tag;
  logic              rs1_pending, rs2_pending, rst_empty;
  logic [CNT_W-1:0]  pending_cnt;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  reg_status_table #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .flush(flush),
    .disp_wr_en(disp_wr_en), .disp_rd_addr(disp_rd_addr), .disp_tag(disp_tag),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_pending(rs1_pending), .rs1_tag(rs1_tag),
    .rs2_pending(rs2_pending), .rs2_tag(rs2_tag),
    .cdb_tag_valid(cdb_tag_valid), .cdb_tag(cdb_tag),
    .pending_cnt(pending_cnt), .rst_empty(rst_empty)
  );

  task automatic chk(input string tg, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tg, obs, exp);
    end
  endtask

  // advance one edge, then let outputs settle away from it
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; disp_wr_en = 0; cdb_tag_valid = 0;
    disp_rd_addr = '0; disp_tag = '0; cdb_tag = '0;
  endtask

  task automatic bind_all();
    for (int r = 1; r < NUM_REGS; r++) begin
      disp_wr_en = 1; disp_rd_addr = ADDR_W'(r); disp_tag = TAG_W'(r);
      tick();
    end
    idle();
  endtask

  task automatic chk_all_clear(input string tg);
    for (int r = 0; r < NUM_REGS; r++) begin
      rs1_addr = ADDR_W'(r); rs2_addr = ADDR_W'(NUM_REGS - 1 - r);
      #1;
      chk({tg, "_rs1p"}, int'(rs1_pending), 0);
      chk({tg, "_rs2t"}, int'(rs2_tag), 0);
    end
    chk({tg, "_cnt"}, int'(pending_cnt), 0);
    chk({tg, "_empty"}, int'(rst_empty), 1);
  endtask

  initial begin
    idle();
    i_rst = 1; rs1_addr = '0; rs2_addr = '0;
    tick(); tick();
    i_rst = 0;
    rs1_addr = 5; #1;
    chk("rst_cnt", int'(pending_cnt), 0);
    chk("rst_empty", int'(rst_empty), 1);
    chk("rst_rs1p", int'(rs1_pending), 0);

    // bind x5 -> 12
    disp_wr_en = 1; disp_rd_addr = 5; disp_tag = 12;
    tick(); idle(); #1;
    chk("b5_rs1p", int'(rs1_pending), 1);
    chk("b5_rs1t", int'(rs1_tag), 12);
    chk("b5_cnt", int'(pending_cnt), 1);
    chk("b5_empty", int'(rst_empty), 0);

    // CDB 12 bypasses the lookup, then clears the entry
    cdb_tag_valid = 1; cdb_tag = 12; #1;
    chk("byp_rs1p", int'(rs1_pending), 0);
    chk("byp_rs1t", int'(rs1_tag), 0);
    tick(); idle(); #1;
    chk("clr_rs1p", int'(rs1_pending), 0);
    chk("clr_cnt", int'(pending_cnt), 0);
    chk("clr_empty", int'(rst_empty), 1);

    // WAW: x7 -> 3 then 9; CDB 3 must not release x7
    disp_wr_en = 1; disp_rd_addr = 7; disp_tag = 3;
    tick();
    chk("waw1_cnt", int'(pending_cnt), 1);
    disp_tag = 9;
    tick(); idle();
    chk("waw2_cnt", int'(pending_cnt), 1);
    rs2_addr = 7; cdb_tag_valid = 1; cdb_tag = 3; #1;
    chk("waw_byp_rs2p", int'(rs2_pending), 1);
    chk("waw_byp_rs2t", int'(rs2_tag), 9);
    tick(); idle(); #1;
    chk("waw_rs2p", int'(rs2_pending), 1);
    chk("waw_rs2t", int'(rs2_tag), 9);
    chk("waw_cnt", int'(pending_cnt), 1);

    // x4 -> 20, then re-bind x4 -> 20 while CDB retires 20: dispatch wins
    disp_wr_en = 1; disp_rd_addr = 4; disp_tag = 20;
    tick();
    chk("b4_cnt", int'(pending_cnt), 2);
    cdb_tag_valid = 1; cdb_tag = 20; rs1_addr = 4; #1;
    chk("coll_byp_rs1p", int'(rs1_pending), 0);
    tick(); idle(); #1;
    chk("coll_rs1p", int'(rs1_pending), 1);
    chk("coll_rs1t", int'(rs1_tag), 20);
    chk("coll_cnt", int'(pending_cnt), 2);

    // different entries: bind x10 -> 30 while CDB 9 retires x7
    disp_wr_en = 1; disp_rd_addr = 10; disp_tag = 30;
    cdb_tag_valid = 1; cdb_tag = 9;
    tick(); idle();
    rs1_addr = 10; rs2_addr = 7; #1;
    chk("diff_rs1t", int'(rs1_tag), 30);
    chk("diff_rs2p", int'(rs2_pending), 0);
    chk("diff_cnt", int'(pending_cnt), 2);

    // lookup of own rd sees prior (empty) binding, not the same-cycle write
    disp_wr_en = 1; disp_rd_addr = 11; disp_tag = 40; rs1_addr = 11; #1;
    chk("nofwd_rs1p", int'(rs1_pending), 0);
    tick(); idle(); #1;
    chk("nofwd_next_rs1t", int'(rs1_tag), 40);
    chk("nofwd_cnt", int'(pending_cnt), 3);

    // x0 writes are dropped
    disp_wr_en = 1; disp_rd_addr = 0; disp_tag = 1;
    tick(); idle();
    rs2_addr = 0; #1;
    chk("x0_rs2p", int'(rs2_pending), 0);
    chk("x0_rs2t", int'(rs2_tag), 0);
    chk("x0_cnt", int'(pending_cnt), 3);

    // full table, then flush with a concurrent dispatch and CDB
    bind_all();
    rs1_addr = 31; rs2_addr = 1; #1;
    chk("full_cnt", int'(pending_cnt), 31);
    chk("full_rs1t", int'(rs1_tag), 31);
    chk("full_rs2t", int'(rs2_tag), 1);
    flush = 1; disp_wr_en = 1; disp_rd_addr = 2; disp_tag = 50;
    cdb_tag_valid = 1; cdb_tag = 5;
    tick(); idle();
    chk_all_clear("flush");

    // full table, then reset with a concurrent dispatch
    bind_all();
    chk("full2_cnt", int'(pending_cnt), 31);
    i_rst = 1; disp_wr_en = 1; disp_rd_addr = 2; disp_tag = 50;
    tick(); i_rst = 0; idle();
    chk_all_clear("reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
